// File: rtl/ascon_pkg.sv
// Shared constants and encodings for the Ascon-Hash256 sequencing controller.
package ascon_pkg;

  // Ascon-Hash256 initial value placed in S_0 before the first permutation.
  localparam logic [63:0] ASCON_HASH_IV = 64'h0000080100cc0002;

  // Rounds per permutation call (p^12).
  localparam int PA_ROUNDS = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IV = 3'd1,
    PERM    = 3'd2,
    ABSORB  = 3'd3,
    SQUEEZE = 3'd4
  } ctrl_state_t;

  // Where PERM hands control back to once the last round has run.
  typedef enum logic {
    RET_ABSORB  = 1'b0,
    RET_SQUEEZE = 1'b1
  } ret_state_t;

endpackage

// File: rtl/ascon_pad.sv
// Message word padding: non-last words pass through; the last word keeps
// its first msg_bytes bytes and gets the 0x01 pad byte right after them.
module ascon_pad (
  input  logic [63:0] msg_data,
  input  logic [2:0]  msg_bytes,
  input  logic        msg_last,
  output logic [63:0] pad_word
);

  // Byte mask plus a single pad bit at bit 8*msg_bytes.
  function automatic logic [63:0] pad_last(input logic [63:0] data,
                                           input logic [2:0]  nbytes);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(nbytes)) begin
        w[8*k +: 8] = data[8*k +: 8];
      end
    end
    w[{nbytes, 3'b000}] = 1'b1;
    return w;
  endfunction

  // Select verbatim or padded word.
  always_comb begin
    pad_word = msg_data;
    if (msg_last) begin
      pad_word = pad_last(msg_data, msg_bytes);
    end
  end

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash256 sequencing controller driving the shared asconp datapath:
// IV load, per-word absorb with padding of the final word, and squeeze of
// DIGEST_WORDS 64-bit digest words, with one p^12 call between phases.
module ascon_hash_ctrl #(
  parameter int DIGEST_WORDS = 4,
  parameter int PA_ROUNDS    = ascon_pkg::PA_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [63:0] msg_data,
  input  logic        msg_last,
  input  logic [2:0]  msg_bytes,
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic [63:0] digest_data,
  output logic        done,
  input  logic [63:0] S_0_reg,
  input  logic [63:0] S_1_reg,
  input  logic [63:0] S_2_reg,
  input  logic [63:0] S_3_reg,
  input  logic [63:0] S_4_reg,
  output logic [63:0] S_0_load_val,
  output logic [63:0] S_1_load_val,
  output logic [63:0] S_2_load_val,
  output logic [63:0] S_3_load_val,
  output logic [63:0] S_4_load_val,
  output logic        load_val,
  output logic [3:0]  num_rounds,
  output logic        rounds_enable,
  output logic [3:0]  round_ctr
);

  import ascon_pkg::*;

  localparam int CNT_W = $clog2(DIGEST_WORDS + 1);

  ctrl_state_t      state, state_next;
  ret_state_t       ret, ret_next;
  logic [3:0]       round_ctr_next;
  logic [CNT_W-1:0] word_cnt, word_cnt_next, word_cnt_inc;
  logic [63:0]      pad_word;

  ascon_pad u_pad (
    .msg_data  (msg_data),
    .msg_bytes (msg_bytes),
    .msg_last  (msg_last),
    .pad_word  (pad_word)
  );

  assign num_rounds   = 4'(PA_ROUNDS);
  assign word_cnt_inc = word_cnt + CNT_W'(1);

  // State, return target, round index and squeezed-word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ret       <= RET_ABSORB;
      round_ctr <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_next;
      ret       <= ret_next;
      round_ctr <= round_ctr_next;
      word_cnt  <= word_cnt_next;
    end
  end

  // Next-state decode and all handshake / datapath-control outputs.
  always_comb begin
    state_next     = state;
    ret_next       = ret;
    round_ctr_next = round_ctr;
    word_cnt_next  = word_cnt;
    busy           = (state != IDLE);
    msg_ready      = 1'b0;
    digest_valid   = 1'b0;
    digest_data    = '0;
    done           = 1'b0;
    load_val       = 1'b0;
    rounds_enable  = 1'b0;
    S_0_load_val   = S_0_reg;
    S_1_load_val   = S_1_reg;
    S_2_load_val   = S_2_reg;
    S_3_load_val   = S_3_reg;
    S_4_load_val   = S_4_reg;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD_IV;
        end
      end

      LOAD_IV: begin
        load_val       = 1'b1;
        S_0_load_val   = ASCON_HASH_IV;
        S_1_load_val   = '0;
        S_2_load_val   = '0;
        S_3_load_val   = '0;
        S_4_load_val   = '0;
        word_cnt_next  = '0;
        round_ctr_next = '0;
        ret_next       = RET_ABSORB;
        state_next     = PERM;
      end

      PERM: begin
        rounds_enable = 1'b1;
        if (round_ctr == 4'(PA_ROUNDS - 1)) begin
          round_ctr_next = '0;
          state_next     = (ret == RET_ABSORB) ? ABSORB : SQUEEZE;
        end else begin
          round_ctr_next = round_ctr + 4'd1;
        end
      end

      ABSORB: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          load_val     = 1'b1;
          S_0_load_val = S_0_reg ^ pad_word;
          ret_next     = msg_last ? RET_SQUEEZE : RET_ABSORB;
          state_next   = PERM;
        end
      end

      SQUEEZE: begin
        digest_valid = 1'b1;
        digest_data  = S_0_reg;
        if (digest_ready) begin
          word_cnt_next = word_cnt_inc;
          if (word_cnt_inc < CNT_W'(DIGEST_WORDS)) begin
            state_next = PERM;
          end else begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
